// File: rtl/lif_array_if.sv
// lif_array_if: control, current input and neuron output bundle for lif_array
interface lif_array_if #(
  parameter int N_NEURONS = 2,
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 8
);
  logic                       enable;
  logic                       chain_en;
  logic                       count_clr;
  logic [WIDTH-1:0]           threshold;
  logic [N_NEURONS*WIDTH-1:0] current;
  logic [N_NEURONS*WIDTH-1:0] state;
  logic [N_NEURONS-1:0]       spike;
  logic [N_NEURONS*CNT_W-1:0] spike_count;

  modport master (
    output enable, chain_en, count_clr, threshold, current,
    input  state, spike, spike_count
  );

  modport slave (
    input  enable, chain_en, count_clr, threshold, current,
    output state, spike, spike_count
  );
endinterface

// File: rtl/lif_array.sv
// lif_array: array of leaky integrate-and-fire neurons with refractory, chaining and spike counters
module lif_array #(
  parameter int N_NEURONS      = 2,
  parameter int WIDTH          = 8,
  parameter int LEAK_SHIFT     = 1,
  parameter int REFRACT_CYCLES = 2,
  parameter int CHAIN_WEIGHT   = 128,
  parameter int CNT_W          = 8
) (
  input logic        clk,
  input logic        reset_n,
  lif_array_if.slave bus
);
  localparam int              RW   = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
  localparam logic [WIDTH+1:0] SMAX = (WIDTH+2)'((1 << WIDTH) - 1);

  logic [N_NEURONS-1:0] w_spike;

  assign bus.spike = w_spike;

  for (genvar i = 0; i < N_NEURONS; i++) begin : g_n
    logic [WIDTH-1:0] r_state;
    logic             r_spike;
    logic [RW-1:0]    r_ref;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH+1:0] w_chain;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH-1:0] w_sat;
    logic             w_fire;

    // The chain term reads the previous neuron's registered spike, one cycle per stage
    if (i > 0) begin : g_c
      assign w_chain = (bus.chain_en && w_spike[i-1]) ? (WIDTH+2)'(CHAIN_WEIGHT) : '0;
    end else begin : g_z
      assign w_chain = '0;
    end

    assign w_sum  = (WIDTH+2)'(bus.current[i*WIDTH +: WIDTH]) + (WIDTH+2)'(r_state >> LEAK_SHIFT) + w_chain;
    assign w_sat  = (w_sum > SMAX) ? '1 : w_sum[WIDTH-1:0];
    assign w_fire = bus.enable && (r_ref == '0) && (w_sat >= bus.threshold);

    // Membrane integration, firing and refractory hold
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        r_state <= '0;
        r_spike <= 1'b0;
        r_ref   <= '0;
      end else if (!bus.enable) begin
        r_spike <= 1'b0;
      end else if (r_ref != '0) begin
        r_state <= '0;
        r_spike <= 1'b0;
        r_ref   <= r_ref - 1'b1;
      end else begin
        r_spike <= w_fire;
        r_state <= w_fire ? '0 : w_sat;
        r_ref   <= w_fire ? RW'(REFRACT_CYCLES) : r_ref;
      end

    // Saturating spike counter; a clear wins over a same-edge spike
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
        r_cnt <= '0;
      else if (bus.count_clr)
        r_cnt <= '0;
      else if (w_fire && !(&r_cnt))
        r_cnt <= r_cnt + 1'b1;

    assign bus.state[i*WIDTH +: WIDTH]       = r_state;
    assign bus.spike_count[i*CNT_W +: CNT_W] = r_cnt;
    assign w_spike[i]                        = r_spike;
  end
endmodule

// File: doc/lif_array.md
Name: lif_array

Overview:
- Parametrised array of N_NEURONS leaky integrate-and-fire neurons. It succeeds the single 8-bit LIF instance in the top wrapper.
- Each neuron integrates its own input current with a shift-based leak and fires against a runtime threshold.
- Each neuron has a configurable refractory period and a saturating per-neuron spike counter.
- An optional chain mode feeds each neuron's spike into the next neuron, so a small feed-forward layer forms inside one tile.

Parameters:
- N_NEURONS, 2, number of neurons (>=1)
- WIDTH, 8, membrane state / current / threshold width in bits
- LEAK_SHIFT, 1, leak term is state >> LEAK_SHIFT (range 1..WIDTH-1)
- REFRACT_CYCLES, 2, enabled cycles a neuron is held at 0 after firing (0 = no refractory)
- CHAIN_WEIGHT, 128, value added to neuron i when spike[i-1] is set and chain_en=1 (must be < 2^WIDTH)
- CNT_W, 8, spike counter width per neuron

Ports:
- clk, input, 1, system clock, rising edge
- reset_n, input, 1, asynchronous active-low reset
- enable, input, 1, advance neuron dynamics this cycle
- chain_en, input, 1, enable spike chaining neuron i-1 -> i
- count_clr, input, 1, synchronous clear of all spike counters
- threshold, input, WIDTH, firing threshold shared by all neurons (unsigned)
- current, input, N_NEURONS*WIDTH, per-neuron input current; neuron i uses bits [i*WIDTH +: WIDTH]
- state, output, N_NEURONS*WIDTH, registered membrane potential per neuron, same packing as current
- spike, output, N_NEURONS, registered one-cycle spike pulse per neuron
- spike_count, output, N_NEURONS*CNT_W, saturating spike count per neuron

Behaviour:
- Reset (reset_n=0, asynchronous): all state, spike, spike_count and internal refractory counters go to 0 immediately. They stay 0 while reset is held.
- All other updates happen on the rising edge of clk only.
- enable=0:
  - state and refractory counters hold.
  - spike <= 0.
  - spike_count still honours count_clr.
- enable=1, per neuron i, refractory counter r_i > 0:
  - state_i <= 0, spike_i <= 0, r_i <= r_i - 1.
  - Inputs are ignored.
- enable=1, r_i == 0:
  - sum = current_i + (state_i >> LEAK_SHIFT) + chain_term_i.
  - sum is computed in WIDTH+2 bits, unsigned.
  - chain_term_i = CHAIN_WEIGHT if (chain_en && i>0 && spike[i-1]==1), else 0.
  - Neuron 0 never receives a chain term.
  - The chain term uses the registered spike, so each chain stage adds one cycle of latency.
  - sat = min(sum, 2^WIDTH-1).
  - sat >= threshold: spike_i <= 1, state_i <= 0, r_i <= REFRACT_CYCLES.
  - Otherwise: spike_i <= 0, state_i <= sat.
- threshold=0: every non-refractory enabled cycle fires. This is legal, not an error.
- Latency: a spike appears on the edge where the crossing sum is evaluated. There are no combinational paths from inputs to outputs.
- spike_count_i:
  - On any edge where spike_i is set to 1, spike_count_i <= spike_count_i + 1.
  - The counter saturates at 2^CNT_W-1 and does not wrap.
  - count_clr=1 has priority: all counters <= 0, and a spike fired on the same edge is not counted.
- Reset mid-refractory or mid-integration: everything clears. The first enabled cycle after release integrates from state 0 with r=0.
- Neurons are independent except for the chain term. Changing chain_en takes effect on the next edge.
- Refractory counter width is clog2(REFRACT_CYCLES+1), minimum 1 bit.

Test Plan:
All scenarios use defaults (N_NEURONS=2, WIDTH=8, LEAK_SHIFT=1, REFRACT_CYCLES=2, CHAIN_WEIGHT=128, CNT_W=8) unless noted.
1. Reset: assert reset_n=0 asynchronously between edges -> state, spike, spike_count all 0 before the next clk edge. Release and apply no stimulus -> outputs remain 0.
2. Periodic firing: enable=1, chain_en=0, threshold=200, current0=120, current1=0.
   - state0 sequence is 120, 180, then 0 with spike0=1 on edge 3.
   - Edges 4-5: state0=0 (refractory), then 120, 180, spike on edge 8 (period 5).
   - spike_count0 reads 2 after edge 8. Neuron 1 stays 0.
3. Saturation: threshold=255, current0=200.
   - Edge 1: state0=200.
   - Edge 2: sum=300 saturates to 255 >= 255 -> spike0=1, state0=0.
   - With threshold=255 and current0=100, state0 converges to 199 and never fires.
4. Chain: chain_en=1, threshold=100, current0=255, current1=0.
   - Edge 1: spike0=1, neuron 1 unaffected.
   - Edge 2: neuron 1 sum=128 -> spike1=1.
   - With chain_en=0, the same stimulus never fires neuron 1.
5. Enable gating: current0=60, threshold=200. After 2 enabled edges (state0=60, 90), drop enable for 3 edges -> state0 holds 90, spike0=0. Re-enable -> state0=105.
6. Counter rules:
   - threshold=0 and current0=0 with REFRACT_CYCLES=0 and CNT_W=2: spike0 is 1 every edge, and spike_count0 saturates at 3.
   - Assert count_clr on a firing edge -> spike_count0=0 on that edge, then 1 on the next firing edge.
